// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage MIPS pipeline.
// Owns PCF and the IF/ID register. Talks to instruction memory over a request/ready
// port that may take several cycles per fetch, and never loses or duplicates a word.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   StallF, StallD      - hazard-unit stalls (always asserted together)
//   PCSrcD, PCBranchD   - taken-branch decision and target from decode
//   imem_req/imem_addr  - fetch request and word address (held until imem_ready)
//   imem_ready/rdata    - response strobe and instruction word
//   InstrD/PCPlus4D     - IF/ID instruction (0 = nop bubble) and its PC+4
//   ValidD              - IF/ID holds a real instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain
    } state_e;

    state_e      r_state;
    logic [31:0] r_pcf;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_buffer;      // word that arrived while decode was stalled
    logic [31:0] r_drain_addr;  // address of the stale request still in flight

    logic        w_stall;
    logic [31:0] w_pcf_plus4;

    // StallF never appears without StallD, so either one freezes the front end.
    assign w_stall     = StallD | StallF;
    assign w_pcf_plus4 = r_pcf + 32'd4;

    assign imem_req  = (r_state == StFetch) || (r_state == StDrain);
    assign imem_addr = (r_state == StDrain) ? r_drain_addr : r_pcf;

    assign InstrD   = r_instr;
    assign PCPlus4D = r_pc4;
    assign ValidD   = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_pcf        <= RESET_PC;
            r_instr      <= 32'h0;
            r_pc4        <= 32'h0;
            r_valid      <= 1'b0;
            r_buffer     <= 32'h0;
            r_drain_addr <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state <= StFetch;
                end

                StFetch: begin
                    if (PCSrcD && !w_stall) begin
                        r_pcf   <= PCBranchD;
                        r_instr <= 32'h0;
                        r_valid <= 1'b0;
                        // A request still in flight must complete before the target
                        // address can be presented.
                        if (!imem_ready) begin
                            r_drain_addr <= r_pcf;
                            r_state      <= StDrain;
                        end
                    end else if (imem_ready && !w_stall) begin
                        r_instr <= imem_rdata;
                        r_pc4   <= w_pcf_plus4;
                        r_valid <= 1'b1;
                        r_pcf   <= w_pcf_plus4;
                    end else if (imem_ready) begin
                        r_buffer <= imem_rdata;
                        r_state  <= StHold;
                    end else if (!w_stall) begin
                        r_instr <= 32'h0;
                        r_valid <= 1'b0;
                    end
                end

                StHold: begin
                    if (PCSrcD && !w_stall) begin
                        r_pcf   <= PCBranchD;
                        r_instr <= 32'h0;
                        r_valid <= 1'b0;
                        r_state <= StFetch;
                    end else if (!w_stall) begin
                        r_instr <= r_buffer;
                        r_pc4   <= w_pcf_plus4;
                        r_valid <= 1'b1;
                        r_pcf   <= w_pcf_plus4;
                        r_state <= StFetch;
                    end
                end

                StDrain: begin
                    // Branch already redirected PCF; a second one here is ignored.
                    if (!w_stall) begin
                        r_instr <= 32'h0;
                        r_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        r_state <= StFetch;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;

    // Index 0: default RESET_PC, index 1: RESET_PC = 0x0040_0000.
    logic        req   [2];
    logic [31:0] addr  [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic [31:0] instr [2];
    logic [31:0] pc4   [2];
    logic        valid [2];

    int unsigned wcnt [2];
    int unsigned mem_lat;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (req[0]),
        .imem_addr  (addr[0]),
        .imem_ready (ready[0]),
        .imem_rdata (rdata[0]),
        .InstrD     (instr[0]),
        .PCPlus4D   (pc4[0]),
        .ValidD     (valid[0])
    );

    fetch_unit #(
        .RESET_PC (32'h0040_0000)
    ) u_dut_hi (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (req[1]),
        .imem_addr  (addr[1]),
        .imem_ready (ready[1]),
        .imem_rdata (rdata[1]),
        .InstrD     (instr[1]),
        .PCPlus4D   (pc4[1]),
        .ValidD     (valid[1])
    );

    // Memory model: ready after mem_lat wait cycles, data = 0x1000_0000 | addr.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = req[i] && (wcnt[i] == mem_lat);
            rdata[i] = 32'h1000_0000 | addr[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            wcnt[i] <= (!req[i] || ready[i]) ? 0 : wcnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected (InstrD, PCPlus4D) in the order decode consumes them.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    logic        p_req   = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_rst   = 1'b1;
    logic [31:0] p_addr  = 32'h0;

    // Monitor: decode consumes IF/ID on any cycle with ValidD=1 and no stall.
    always @(negedge clk) begin
        if (!rst && valid[0] && !StallD) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got instr %h pc4 %h, expected nothing", instr[0], pc4[0]);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_instr", instr[0], sb_e.instr);
                check("sb_pc4", pc4[0], sb_e.pc4);
            end
        end
        if (p_req && !p_ready && !p_rst) begin
            check("req_held", {31'd0, req[0]}, 32'd1);
            check("addr_stable", addr[0], p_addr);
        end
        p_req   = req[0];
        p_ready = ready[0];
        p_rst   = rst;
        p_addr  = addr[0];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i_instr, input logic [31:0] i_pc4);
        sb_q.push_back({i_instr, i_pc4});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        StallF    = 1'b0;
        StallD    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        cyc();
        cyc();
        check("rst_valid", {31'd0, valid[0]}, 32'd0);
        check("rst_instr", instr[0], 32'h0);
        check("rst_pc4", pc4[0], 32'h0);
        check("rst_req", {31'd0, req[0]}, 32'd0);
        check("rst_addr", addr[0], 32'h0);
        check("rst_addr_hi", addr[1], 32'h0040_0000);
        check("sb_drained", sb_q.size(), 32'd0);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst       = 1'b1;
        StallF    = 1'b0;
        StallD    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        mem_lat   = 0;

        // Sequential fetch, then a taken branch while fetching 0x8.
        do_reset();
        push(32'h1000_0000, 32'h4);
        push(32'h1000_0004, 32'h8);
        push(32'h1000_0040, 32'h44);
        release_rst();
        check("t1_first_req", {31'd0, req[0]}, 32'd1);
        check("t1_first_addr", addr[0], 32'h0);
        check("t1_first_valid", {31'd0, valid[0]}, 32'd0);
        for (int k = 2; k <= 3; k++) begin
            cyc();
            check("t1_addr_seq", addr[0], 32'(4 * (k - 1)));
        end
        PCSrcD    = 1'b1;
        PCBranchD = 32'h40;
        cyc();
        check("t2_bubble_valid", {31'd0, valid[0]}, 32'd0);
        check("t2_bubble_instr", instr[0], 32'h0);
        check("t2_bubble_pc4", pc4[0], 32'h8);
        check("t2_target_addr", addr[0], 32'h40);
        PCSrcD = 1'b0;
        cyc();
        check("t2_after_target", addr[0], 32'h44);
        cyc();

        // Response for 0x8 arrives while stalled for three cycles.
        do_reset();
        push(32'h1000_0000, 32'h4);
        push(32'h1000_0004, 32'h8);
        push(32'h1000_0008, 32'hC);
        release_rst();
        cyc();
        cyc();
        StallF = 1'b1;
        StallD = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            cyc();
            check("t3_hold_req", {31'd0, req[0]}, 32'd0);
            check("t3_hold_instr", instr[0], 32'h1000_0004);
            check("t3_hold_pc4", pc4[0], 32'h8);
        end
        StallF = 1'b0;
        StallD = 1'b0;
        cyc();
        check("t3_release_instr", instr[0], 32'h1000_0008);
        check("t3_release_pc4", pc4[0], 32'hC);
        check("t3_next_addr", addr[0], 32'hC);
        check("t3_next_req", {31'd0, req[0]}, 32'd1);
        cyc();
        check("t3_following_addr", addr[0], 32'h10);

        // Three-cycle memory latency.
        do_reset();
        mem_lat = 2;
        push(32'h1000_0000, 32'h4);
        push(32'h1000_0004, 32'h8);
        push(32'h1000_0008, 32'hC);
        release_rst();
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) cyc();
            check("t4_addr", addr[0], 32'(4 * ((k - 1) / 3)));
            check("t4_valid", {31'd0, valid[0]}, (k >= 4 && (k - 1) % 3 == 0) ? 32'd1 : 32'd0);
        end
        cyc();

        // Branch while the request to 0x20 is outstanding: drain first.
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 8; i++) begin
            push(32'h1000_0000 | 32'(4 * i), 32'(4 * i + 4));
        end
        push(32'h1000_0100, 32'h104);
        release_rst();
        for (int k = 2; k <= 9; k++) cyc();
        check("t5_pre_addr", addr[0], 32'h20);
        mem_lat   = 2;
        PCSrcD    = 1'b1;
        PCBranchD = 32'h100;
        cyc();
        check("t5_drain_addr", addr[0], 32'h20);
        check("t5_drain_req", {31'd0, req[0]}, 32'd1);
        check("t5_drain_valid", {31'd0, valid[0]}, 32'd0);
        PCBranchD = 32'h200;  // branch during drain must be ignored
        cyc();
        check("t5_drain_addr2", addr[0], 32'h20);
        check("t5_drain_valid2", {31'd0, valid[0]}, 32'd0);
        check("t5_drain_pc4", pc4[0], 32'h20);
        PCSrcD = 1'b0;
        cyc();
        check("t5_target_addr", addr[0], 32'h100);
        check("t5_target_valid", {31'd0, valid[0]}, 32'd0);
        mem_lat = 0;
        cyc();
        check("t5_target_instr", instr[0], 32'h1000_0100);
        check("t5_target_pc4", pc4[0], 32'h104);
        check("t5_next_addr", addr[0], 32'h104);
        cyc();

        // Reset during HOLD on the instance with RESET_PC = 0x0040_0000.
        do_reset();
        mem_lat = 0;
        release_rst();
        check("t6_first_addr", addr[1], 32'h0040_0000);
        check("t6_first_req", {31'd0, req[1]}, 32'd1);
        cyc();
        StallF = 1'b1;
        StallD = 1'b1;
        check("t6_valid", {31'd0, valid[1]}, 32'd1);
        cyc();
        check("t6_hold_req", {31'd0, req[1]}, 32'd0);
        check("t6_hold_instr", instr[1], 32'h1040_0000);
        rst = 1'b1;
        cyc();
        check("t6_rst_valid", {31'd0, valid[1]}, 32'd0);
        check("t6_rst_instr", instr[1], 32'h0);
        check("t6_rst_pc4", pc4[1], 32'h0);
        check("t6_rst_req", {31'd0, req[1]}, 32'd0);
        rst    = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        cyc();
        check("t6_restart_req", {31'd0, req[1]}, 32'd1);
        check("t6_restart_addr", addr[1], 32'h0040_0000);

        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch stage of the 5-stage MIPS pipeline. Owns PCF and the IF/ID pipeline register, and consumes the decode-stage branch decision (PCSrcD/PCBranchD) and the hazard-unit stalls. Drives a request/ready instruction-memory port that may take several cycles per fetch. It delivers InstrD/PCPlus4D to decode, inserts bubbles on taken branches and on memory wait states, and never loses or duplicates a fetched instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  synchronous reset, active-high.
StallF  input  1  hazard unit: hold PCF.
StallD  input  1  hazard unit: hold IF/ID. Always asserted together with StallF.
PCSrcD  input  1  branch taken in decode. Honoured only when StallD=0.
PCBranchD  input  32  branch target from decode.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address. Word aligned.
imem_ready  input  1  response valid this cycle. Meaningful only while imem_req=1.
imem_rdata  input  32  instruction word. Valid when imem_ready=1.
InstrD  output  32  IF/ID instruction. 32'h0 (nop) when bubble.
PCPlus4D  output  32  IF/ID PC+4 of InstrD.
ValidD  output  1  IF/ID holds a real instruction.

Behaviour:
- All state updates on rising clk. rst has priority over everything.
- Reset values: state=IDLE, PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, buffer=0, drain_addr=0.
- imem_req is decoded from state: 1 in FETCH and DRAIN, 0 in IDLE and HOLD. imem_addr=PCF in FETCH, drain_addr in DRAIN, PCF otherwise.
- Memory protocol: once imem_req=1, imem_addr stays stable until the cycle imem_ready=1. Exactly one response per request.
- "Bubble" means InstrD<=0, ValidD<=0, PCPlus4D unchanged. "Hold" means IF/ID unchanged.
- PC arithmetic is 32-bit modulo; PCF+4 wraps 0xFFFFFFFC -> 0x0.
- IDLE: -> FETCH unconditionally. First request is issued the cycle after rst deasserts.
- FETCH, in priority order:
  - PCSrcD & !StallD: PCF<=PCBranchD; IF/ID bubble.
    - If imem_ready: discard rdata, stay FETCH.
    - Else: drain_addr<=PCF, -> DRAIN.
  - imem_ready & !StallD: InstrD<=imem_rdata, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4; stay FETCH.
  - imem_ready & StallD: buffer<=imem_rdata; IF/ID hold; PCF hold; -> HOLD.
  - !imem_ready & !StallD: IF/ID bubble; stay FETCH.
  - !imem_ready & StallD: IF/ID hold; stay FETCH.
- HOLD (no request outstanding):
  - PCSrcD & !StallD: drop buffer, PCF<=PCBranchD, IF/ID bubble, -> FETCH.
  - !StallD: InstrD<=buffer, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4, -> FETCH.
  - StallD: hold everything.
- DRAIN (finishing the stale request):
  - imem_req=1 at drain_addr; PCSrcD ignored.
  - IF/ID bubble if !StallD, hold if StallD.
  - On imem_ready: drop rdata, -> FETCH (now fetching the new PCF).
- Branch latency: target address appears on imem_addr the cycle after PCSrcD if no drain is needed; otherwise the cycle after the drain response.
- Reset mid-operation (any state, including an outstanding request): return to IDLE. The memory must tolerate request withdrawal on reset. The first post-reset request is to RESET_PC.

Test Plan:
1. Reset with default RESET_PC, memory returning 0x1000_0000|addr with zero-wait ready -> imem_addr 0,4,8...; InstrD 0x1000_0000, 0x1000_0004...; PCPlus4D 4,8,...; ValidD=1 from 2nd post-reset cycle.
2. Zero-wait memory, PCSrcD=1, PCBranchD=0x40 while fetching 0x8 -> one cycle ValidD=0/InstrD=0; next imem_addr=0x40; then InstrD=0x1000_0040, PCPlus4D=0x44; 0x8 never delivered.
3. Ready arrives for 0x8 while StallF=StallD=1 for 3 cycles -> imem_req=0 during HOLD, IF/ID constant; after release InstrD=0x1000_0008, PCPlus4D=0xC; next imem_addr=0xC; no duplicate or skipped fetch.
4. 3-cycle memory latency -> imem_addr stable 3 cycles per fetch; ValidD=0 for 2 of every 3 cycles; PCPlus4D sequence 4,8,12 with no gaps.
5. PCSrcD=1 (target 0x100) while the request to 0x20 is outstanding, ready 2 cycles later -> DRAIN keeps imem_addr=0x20 until ready; data dropped; next imem_addr=0x100; ValidD=0 throughout.
6. rst asserted during HOLD with RESET_PC=0x0040_0000 -> next cycle ValidD=0, InstrD=0, PCPlus4D=0, imem_req=0; after release the first imem_addr is 0x0040_0000.
